// File: rtl/hazard_stall_controller.sv
// Hazard/sequencing controller: RAW stall, branch flush, vector-op issue hold, forwarding selects, stall counter.
// Optional macro FORWARDING_EN: enables execute-stage forwarding; undefined stalls on any execute/memory RAW.
module hazard_stall_controller #(
  parameter int VEC_LATENCY = 4,
  parameter int REG_ADDR_W  = 4,
  parameter int PERF_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_decode,
  input  logic [REG_ADDR_W-1:0] rs2_decode,
  input  logic                  uses_rs1_decode,
  input  logic                  uses_rs2_decode,
  input  logic                  vector_op_decode,
  input  logic [REG_ADDR_W-1:0] rs1_execute,
  input  logic [REG_ADDR_W-1:0] rs2_execute,
  input  logic [REG_ADDR_W-1:0] rd_execute,
  input  logic                  wre_execute,
  input  logic                  load_execute,
  input  logic                  branch_taken_execute,
  input  logic [REG_ADDR_W-1:0] rd_memory,
  input  logic                  wre_memory,
  input  logic [REG_ADDR_W-1:0] rd_writeback,
  input  logic                  wre_writeback,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  nop_select,
  output logic                  flush_decode,
  output logic [1:0]            forward_a_sel,
  output logic [1:0]            forward_b_sel,
  output logic                  vec_busy,
  output logic [PERF_W-1:0]     stall_cycles
);

  typedef enum logic [0:0] {RUN = 1'b0, VEC_BUSY = 1'b1} state_t;

  localparam logic [3:0] VEC_CNT_INIT = 4'(VEC_LATENCY - 1);

  state_t            r_state, w_nextState;
  logic [3:0]        r_vecCnt, w_nextVecCnt;
  logic [PERF_W-1:0] r_stallCycles;
  logic              w_srcHitExecute, w_rawStall;
  logic              w_stallFetch, w_stallDecode, w_nopSelect, w_flushDecode, w_vecBusy;
  logic [1:0]        w_forwardA, w_forwardB;

  assign w_srcHitExecute = wre_execute &
                           ((uses_rs1_decode & (rs1_decode == rd_execute)) |
                            (uses_rs2_decode & (rs2_decode == rd_execute)));

`ifdef FORWARDING_EN
  assign w_rawStall = load_execute & w_srcHitExecute;

  // Memory stage holds the younger result, so it wins over writeback
  always_comb begin
    w_forwardA = 2'b00;
    w_forwardB = 2'b00;
    if (wre_memory && (rd_memory == rs1_execute))
      w_forwardA = 2'b10;
    else if (wre_writeback && (rd_writeback == rs1_execute))
      w_forwardA = 2'b01;
    if (wre_memory && (rd_memory == rs2_execute))
      w_forwardB = 2'b10;
    else if (wre_writeback && (rd_writeback == rs2_execute))
      w_forwardB = 2'b01;
  end
`else
  logic w_srcHitMemory;
  logic w_unusedFwd;

  // Write-first register file covers writeback, so only execute and memory stall
  assign w_srcHitMemory = wre_memory &
                          ((uses_rs1_decode & (rs1_decode == rd_memory)) |
                           (uses_rs2_decode & (rs2_decode == rd_memory)));
  assign w_rawStall  = w_srcHitExecute | w_srcHitMemory;
  assign w_forwardA  = 2'b00;
  assign w_forwardB  = 2'b00;
  assign w_unusedFwd = ^{rs1_execute, rs2_execute, rd_writeback, wre_writeback, load_execute};
`endif

  always_comb begin
    w_nextState   = r_state;
    w_nextVecCnt  = r_vecCnt;
    w_stallFetch  = 1'b0;
    w_stallDecode = 1'b0;
    w_nopSelect   = 1'b0;
    w_flushDecode = 1'b0;
    w_vecBusy     = 1'b0;
    case (r_state)
      RUN: begin
        if (branch_taken_execute) begin
          w_flushDecode = 1'b1;
          w_nopSelect   = 1'b1;
        end else if (w_rawStall) begin
          w_stallFetch  = 1'b1;
          w_stallDecode = 1'b1;
          w_nopSelect   = 1'b1;
        end else if (vector_op_decode) begin
          w_nextState  = VEC_BUSY;
          w_nextVecCnt = VEC_CNT_INIT;
        end
      end
      VEC_BUSY: begin
        w_stallFetch  = 1'b1;
        w_stallDecode = 1'b1;
        w_nopSelect   = 1'b1;
        w_vecBusy     = 1'b1;
        w_flushDecode = branch_taken_execute;
        w_nextVecCnt  = r_vecCnt - 4'd1;
        if (r_vecCnt == 4'd1)
          w_nextState = RUN;
      end
    endcase
    if (reset) begin
      w_stallFetch  = 1'b0;
      w_stallDecode = 1'b0;
      w_nopSelect   = 1'b0;
      w_flushDecode = 1'b0;
      w_vecBusy     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_vecCnt      <= 4'd0;
      r_stallCycles <= '0;
    end else begin
      r_state  <= w_nextState;
      r_vecCnt <= w_nextVecCnt;
      if (w_stallDecode && (r_stallCycles != '1))
        r_stallCycles <= r_stallCycles + 1'b1;
    end
  end

  assign stall_fetch   = w_stallFetch;
  assign stall_decode  = w_stallDecode;
  assign nop_select    = w_nopSelect;
  assign flush_decode  = w_flushDecode;
  assign vec_busy      = w_vecBusy;
  assign forward_a_sel = reset ? 2'b00 : w_forwardA;
  assign forward_b_sel = reset ? 2'b00 : w_forwardB;
  assign stall_cycles  = reset ? '0 : r_stallCycles;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench for hazard_stall_controller; expectations follow FORWARDING_EN when it is defined.
module tb_hazard_stall_controller;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk, reset;
  logic [3:0] rs1_decode, rs2_decode, rs1_execute, rs2_execute, rd_execute, rd_memory, rd_writeback;
  logic       uses_rs1_decode, uses_rs2_decode, vector_op_decode;
  logic       wre_execute, load_execute, branch_taken_execute, wre_memory, wre_writeback;
  logic       stall_fetch, stall_decode, nop_select, flush_decode, vec_busy;
  logic [1:0] forward_a_sel, forward_b_sel;
  logic [15:0] stall_cycles;
  logic       p4_stall_fetch, p4_stall_decode, p4_nop_select, p4_flush_decode, p4_vec_busy;
  logic [1:0] p4_forward_a_sel, p4_forward_b_sel;
  logic [3:0] p4_stall_cycles;

  int checks = 0;
  int failures = 0;

  hazard_stall_controller #(.VEC_LATENCY(4), .REG_ADDR_W(4), .PERF_W(16)) dut (
    .clk(clk), .reset(reset),
    .rs1_decode(rs1_decode), .rs2_decode(rs2_decode),
    .uses_rs1_decode(uses_rs1_decode), .uses_rs2_decode(uses_rs2_decode),
    .vector_op_decode(vector_op_decode),
    .rs1_execute(rs1_execute), .rs2_execute(rs2_execute), .rd_execute(rd_execute),
    .wre_execute(wre_execute), .load_execute(load_execute),
    .branch_taken_execute(branch_taken_execute),
    .rd_memory(rd_memory), .wre_memory(wre_memory),
    .rd_writeback(rd_writeback), .wre_writeback(wre_writeback),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .nop_select(nop_select),
    .flush_decode(flush_decode), .forward_a_sel(forward_a_sel), .forward_b_sel(forward_b_sel),
    .vec_busy(vec_busy), .stall_cycles(stall_cycles)
  );

  // Narrow counter instance used only to observe saturation
  hazard_stall_controller #(.VEC_LATENCY(4), .REG_ADDR_W(4), .PERF_W(4)) dutP4 (
    .clk(clk), .reset(reset),
    .rs1_decode(rs1_decode), .rs2_decode(rs2_decode),
    .uses_rs1_decode(uses_rs1_decode), .uses_rs2_decode(uses_rs2_decode),
    .vector_op_decode(vector_op_decode),
    .rs1_execute(rs1_execute), .rs2_execute(rs2_execute), .rd_execute(rd_execute),
    .wre_execute(wre_execute), .load_execute(load_execute),
    .branch_taken_execute(branch_taken_execute),
    .rd_memory(rd_memory), .wre_memory(wre_memory),
    .rd_writeback(rd_writeback), .wre_writeback(wre_writeback),
    .stall_fetch(p4_stall_fetch), .stall_decode(p4_stall_decode), .nop_select(p4_nop_select),
    .flush_decode(p4_flush_decode), .forward_a_sel(p4_forward_a_sel),
    .forward_b_sel(p4_forward_b_sel), .vec_busy(p4_vec_busy), .stall_cycles(p4_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int rs1d, u1, rs2d, u2, vecop;
    int rde, wree, loade, br;
    int rdm, wrem, rs1e, rs2e, rdw, wrew;
    int sf, sd, nop, fl, fa, fb, vb, sc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkVec(string n, int rs1d, int u1, int rs2d, int u2, int vecop,
                                 int rde, int wree, int loade, int br,
                                 int rdm, int wrem, int rs1e, int rs2e, int rdw, int wrew,
                                 int sf, int sd, int nop, int fl, int fa, int fb, int vb, int sc);
    vec_t v;
    v.name = n; v.rs1d = rs1d; v.u1 = u1; v.rs2d = rs2d; v.u2 = u2; v.vecop = vecop;
    v.rde = rde; v.wree = wree; v.loade = loade; v.br = br;
    v.rdm = rdm; v.wrem = wrem; v.rs1e = rs1e; v.rs2e = rs2e; v.rdw = rdw; v.wrew = wrew;
    v.sf = sf; v.sd = sd; v.nop = nop; v.fl = fl; v.fa = fa; v.fb = fb; v.vb = vb; v.sc = sc;
    return v;
  endfunction

  task automatic clearInputs();
    rs1_decode = 0; rs2_decode = 0; uses_rs1_decode = 0; uses_rs2_decode = 0;
    vector_op_decode = 0; rs1_execute = 0; rs2_execute = 0; rd_execute = 0;
    wre_execute = 0; load_execute = 0; branch_taken_execute = 0;
    rd_memory = 0; wre_memory = 0; rd_writeback = 0; wre_writeback = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    rs1_decode = 4'(v.rs1d); uses_rs1_decode = 1'(v.u1);
    rs2_decode = 4'(v.rs2d); uses_rs2_decode = 1'(v.u2);
    vector_op_decode = 1'(v.vecop);
    rd_execute = 4'(v.rde); wre_execute = 1'(v.wree); load_execute = 1'(v.loade);
    branch_taken_execute = 1'(v.br);
    rd_memory = 4'(v.rdm); wre_memory = 1'(v.wrem);
    rs1_execute = 4'(v.rs1e); rs2_execute = 4'(v.rs2e);
    rd_writeback = 4'(v.rdw); wre_writeback = 1'(v.wrew);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic checkCtl(input string n, input int sf, input int sd, input int nop,
                          input int fl, input int vb);
    checkOutput({n, "/stall_fetch"}, int'(stall_fetch), sf);
    checkOutput({n, "/stall_decode"}, int'(stall_decode), sd);
    checkOutput({n, "/nop_select"}, int'(nop_select), nop);
    checkOutput({n, "/flush_decode"}, int'(flush_decode), fl);
    checkOutput({n, "/vec_busy"}, int'(vec_busy), vb);
  endtask

  task automatic checkAll(input vec_t v);
    checkCtl(v.name, v.sf, v.sd, v.nop, v.fl, v.vb);
    checkOutput({v.name, "/forward_a_sel"}, int'(forward_a_sel), v.fa);
    checkOutput({v.name, "/forward_b_sel"}, int'(forward_b_sel), v.fb);
    checkOutput({v.name, "/stall_cycles"}, int'(stall_cycles), v.sc);
  endtask

  initial begin
    int base;
    // name rs1d u1 rs2d u2 vec | rde wree ld br | rdm wrem rs1e rs2e rdw wrew | sf sd nop fl fa fb vb sc
    tbl.push_back(mkVec("idle0", 0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0,0, 0));
    tbl.push_back(mkVec("load_use", 3,1,0,0,0, 3,1,1,0, 0,0,0,0,0,0, 1,1,1,0,0,0,0, 0));
    tbl.push_back(mkVec("bubble", 0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0,0, 1));
    tbl.push_back(mkVec("exec_raw", 0,0,7,1,0, 7,1,0,0, 0,0,0,0,0,0,
                        !FWD,!FWD,!FWD,0,0,0,0, 1));
    tbl.push_back(mkVec("idle1", 0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0,0, FWD ? 1 : 2));
    tbl.push_back(mkVec("branch_vs_hazard", 3,1,0,0,1, 3,1,1,1, 0,0,0,0,0,0,
                        0,0,1,1,0,0,0, FWD ? 1 : 2));
    tbl.push_back(mkVec("idle2", 0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0,0, FWD ? 1 : 2));
    tbl.push_back(mkVec("mem_raw", 0,0,2,1,0, 0,0,0,0, 2,1,0,0,0,0,
                        !FWD,!FWD,!FWD,0,0,0,0, FWD ? 1 : 2));
    tbl.push_back(mkVec("mem_no_use", 0,0,2,0,0, 0,0,0,0, 2,1,0,0,0,0,
                        0,0,0,0,0,0,0, FWD ? 1 : 3));
    tbl.push_back(mkVec("fwd_mem_wins", 0,0,0,0,0, 0,0,0,0, 5,1,5,6,5,1,
                        0,0,0,0, FWD ? 2 : 0, 0, 0, FWD ? 1 : 3));
    tbl.push_back(mkVec("fwd_wb", 0,0,0,0,0, 0,0,0,0, 5,0,5,6,5,1,
                        0,0,0,0, FWD ? 1 : 0, 0, 0, FWD ? 1 : 3));
    tbl.push_back(mkVec("fwd_both", 0,0,0,0,0, 0,0,0,0, 5,1,5,5,5,1,
                        0,0,0,0, FWD ? 2 : 0, FWD ? 2 : 0, 0, FWD ? 1 : 3));
    tbl.push_back(mkVec("wb_hit_no_stall", 4,1,0,0,0, 0,0,0,0, 0,0,0,0,4,1,
                        0,0,0,0,0,0,0, FWD ? 1 : 3));
    tbl.push_back(mkVec("reg0_hazard", 0,1,0,0,0, 0,1,1,0, 0,0,0,0,0,0,
                        1,1,1,0,0,0,0, FWD ? 1 : 3));
    tbl.push_back(mkVec("idle3", 0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0,0, FWD ? 2 : 4));

    // Reset with hazard, vector and forwarding inputs all active
    reset = 1'b1;
    clearInputs();
    rs1_decode = 3; uses_rs1_decode = 1; rd_execute = 3; wre_execute = 1; load_execute = 1;
    vector_op_decode = 1; rd_memory = 5; wre_memory = 1; rs1_execute = 5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkCtl("reset", 0, 0, 0, 0, 0);
    checkOutput("reset/forward_a_sel", int'(forward_a_sel), 0);
    checkOutput("reset/stall_cycles", int'(stall_cycles), 0);
    @(negedge clk);
    reset = 1'b0;
    clearInputs();

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      #1;
      checkAll(tbl[i]);
      @(negedge clk);
    end

    // Vector op: three bubbles, branch during busy flushes without disturbing the count
    base = FWD ? 2 : 4;
    clearInputs();
    vector_op_decode = 1;
    #1; checkCtl("vec_issue", 0, 0, 0, 0, 0);
    @(negedge clk); vector_op_decode = 0;
    #1; checkCtl("vec_busy1", 1, 1, 1, 0, 1);
    @(negedge clk); branch_taken_execute = 1;
    #1; checkCtl("vec_busy2_branch", 1, 1, 1, 1, 1);
    @(negedge clk); branch_taken_execute = 0;
    #1; checkCtl("vec_busy3", 1, 1, 1, 0, 1);
    @(negedge clk);
    #1; checkCtl("vec_done", 0, 0, 0, 0, 0);
    checkOutput("vec_done/stall_cycles", int'(stall_cycles), base + 3);

    // Reset while vec_cnt is 2
    @(negedge clk); vector_op_decode = 1;
    @(negedge clk); vector_op_decode = 0;
    @(negedge clk);
    #1; checkCtl("rst_pre", 1, 1, 1, 0, 1);
    reset = 1'b1;
    #1; checkCtl("rst_mid", 0, 0, 0, 0, 0);
    checkOutput("rst_mid/stall_cycles", int'(stall_cycles), 0);
    @(negedge clk);
    #1; checkCtl("rst_hold", 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1; checkCtl("rst_after", 0, 0, 0, 0, 0);
    checkOutput("rst_after/stall_cycles", int'(stall_cycles), 0);

    // Hold a load-use stall for 20 edges; the 4-bit counter must stop at 15
    @(negedge clk);
    rs1_decode = 3; uses_rs1_decode = 1; rd_execute = 3; wre_execute = 1; load_execute = 1;
    #1; checkCtl("sat_stall", 1, 1, 1, 0, 0);
    repeat (20) @(negedge clk);
    clearInputs();
    #1;
    checkOutput("sat_main/stall_cycles", int'(stall_cycles), 20);
    checkOutput("sat_p4/stall_cycles", int'(p4_stall_cycles), 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central hazard and sequencing controller for the 16-bit five-stage core.
- Detects load-use and RAW hazards and drives stall/hold of the fetch and decode stages.
- Drives the decode-stage nop mux select so a bubble is written into the decode/execute register, and flushes fetch/decode on taken branches.
- Holds issue for the full latency of multi-cycle vector ops, generates execute-stage operand forwarding selects, and keeps a saturating stall-cycle performance counter.

Parameters:
- VEC_LATENCY, 4, cycles a vector op occupies execute; legal range 2..15.
- REG_ADDR_W, 4, register specifier width.
- PERF_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rs1_decode  in  REG_ADDR_W  source 1 of instruction in decode
- rs2_decode  in  REG_ADDR_W  source 2 of instruction in decode
- uses_rs1_decode  in  1  decode instruction reads rs1
- uses_rs2_decode  in  1  decode instruction reads rs2
- vector_op_decode  in  1  decode instruction is a multi-cycle vector op
- rs1_execute  in  REG_ADDR_W  source 1 in execute
- rs2_execute  in  REG_ADDR_W  source 2 in execute
- rd_execute  in  REG_ADDR_W  destination in execute
- wre_execute  in  1  execute instruction writes the register file
- load_execute  in  1  execute instruction is a load
- branch_taken_execute  in  1  branch resolved taken in execute
- rd_memory  in  REG_ADDR_W  destination in memory stage
- wre_memory  in  1  memory-stage instruction writes the register file
- rd_writeback  in  REG_ADDR_W  destination in writeback
- wre_writeback  in  1  writeback instruction writes the register file
- stall_fetch  out  1  hold PC
- stall_decode  out  1  hold fetch/decode register
- nop_select  out  1  select nop word into the decode/execute register
- flush_decode  out  1  clear fetch/decode register
- forward_a_sel  out  2  srcA source: 00 register file, 01 writeback, 10 memory
- forward_b_sel  out  2  srcB source, same encoding
- vec_busy  out  1  vector op in flight
- stall_cycles  out  PERF_W  saturating count of cycles with stall_decode=1

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- While reset=1: all outputs are 0, state goes to RUN, vec_cnt=0, stall_cycles=0.
- Outputs are combinational from state, vec_cnt and the current inputs; there is no added latency.
- States:
  - RUN: no vector op in flight.
  - VEC_BUSY: a vector op is in flight; vec_cnt is 4 bits.
- src_hit_X (X a stage): (uses_rs1_decode & rs1_decode==rd_X) | (uses_rs2_decode & rs2_decode==rd_X), qualified by wre_X. Register 0 is not exempt.
- raw_stall:
  - With forwarding: load_execute & src_hit_execute.
  - Without forwarding: see Optional Feature.
- Priority in RUN, highest first:
  1. branch_taken_execute: flush_decode=1, nop_select=1, stall_fetch=0, stall_decode=0. Any raw_stall or vector issue in the same cycle is suppressed. State stays RUN.
  2. raw_stall: stall_fetch=1, stall_decode=1, nop_select=1. State stays RUN, and the condition re-evaluates every cycle.
  3. vector_op_decode=1: the op issues normally (no stall this cycle). Next state is VEC_BUSY with vec_cnt=VEC_LATENCY-1.
  4. Otherwise all control outputs are 0.
- VEC_BUSY:
  - stall_fetch=1, stall_decode=1, nop_select=1, vec_busy=1.
  - vec_cnt decrements each cycle. When vec_cnt==1, next state is RUN; the first cycle with issue allowed again is the cycle after vec_cnt reaches 0.
  - Total bubbles behind a vector op = VEC_LATENCY-1.
  - If branch_taken_execute=1 in VEC_BUSY: flush_decode=1 as well. The count continues and the state is unchanged.
- Forwarding, for srcA (srcB the same using rs2_execute):
  - forward_a_sel=10 if wre_memory & rd_memory==rs1_execute.
  - Otherwise 01 if wre_writeback & rd_writeback==rs1_execute.
  - Otherwise 00.
  - Memory stage wins when both match.
- stall_cycles increments by 1 on each clock edge where stall_decode=1 and reset=0. It saturates at all-ones and never wraps.
- Reset mid-VEC_BUSY: state returns to RUN on the next edge and stalls deassert immediately while reset=1.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined:
  - Forwarding selects operate as above.
  - raw_stall = load_execute & src_hit_execute (load-use only).
- Undefined:
  - forward_a_sel and forward_b_sel are tied to 00.
  - raw_stall = src_hit_execute | src_hit_memory. The register file is write-first, so writeback needs no stall.
  - All other behaviour is unchanged.

Test Plan:
- Load-use (FORWARDING_EN): load_execute=1, wre_execute=1, rd_execute=3; rs1_decode=3, uses_rs1_decode=1 -> one cycle with stall_fetch=stall_decode=nop_select=1; next cycle (bubble in execute) all 0; stall_cycles=1.
- Branch versus hazard: same-cycle branch_taken_execute=1 with load-use conditions -> flush_decode=1, nop_select=1, stall_fetch=0, stall_decode=0; stall_cycles unchanged.
- Vector op, VEC_LATENCY=4: vector_op_decode=1 in RUN -> next 3 cycles vec_busy=1 with stalls; 4th cycle RUN with stalls 0; stall_cycles=3.
- Forward priority: rd_memory=rd_writeback=5, both wre=1, rs1_execute=5, rs2_execute=6 -> forward_a_sel=10, forward_b_sel=00. Then set wre_memory=0 -> forward_a_sel=01.
- No FORWARDING_EN: rd_memory=2, wre_memory=1, rs2_decode=2, uses_rs2_decode=1 -> stall asserted and forward selects 00. With uses_rs2_decode=0 -> no stall.
- Reset in VEC_BUSY plus saturation: assert reset at vec_cnt=2 -> outputs 0 while reset=1, RUN afterwards. Force PERF_W=4 and hold a stall for 20 cycles -> stall_cycles=15.
